// File: rtl/typing_round_if.sv
// Handshake bundle between the typing round sequencer and its neighbours
// (keyboard compare stage on the input side, timer/display on the output side).
interface typing_round_if;
  logic       start;
  logic       pause;
  logic       key_valid;
  logic       key_correct;
  logic [2:0] state;
  logic       timer_clear;
  logic       timer_enable;
  logic [3:0] countdown;
  logic [3:0] elapsed;
  logic [3:0] char_idx;
  logic [3:0] error_cnt;
  logic       done;
  logic [1:0] result;

  modport master (
    output start, pause, key_valid, key_correct,
    input  state, timer_clear, timer_enable, countdown, elapsed,
           char_idx, error_cnt, done, result
  );

  modport slave (
    input  start, pause, key_valid, key_correct,
    output state, timer_clear, timer_enable, countdown, elapsed,
           char_idx, error_cnt, done, result
  );
endinterface

// File: rtl/typing_round_ctrl.sv
// Round sequencer for the typing tutor: pre-round countdown, keystroke scoring,
// round termination on completion / error limit / time limit, result hold.
module typing_round_ctrl #(
  parameter int TICK_DIV   = 4,
  parameter int COUNTDOWN  = 3,
  parameter int TIME_LIMIT = 15,
  parameter int WORD_LEN   = 8,
  parameter int MAX_ERRORS = 3
) (
  input  logic          clk,
  input  logic          reset,
  typing_round_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RUN       = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam int             PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]     CD_LOAD    = 4'(COUNTDOWN);
  localparam logic [3:0]     TL_VAL     = 4'(TIME_LIMIT);
  localparam logic [3:0]     WL_VAL     = 4'(WORD_LEN);
  localparam logic [3:0]     ME_VAL     = 4'(MAX_ERRORS);

  state_t        state_r, state_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [3:0]    countdown_r, countdown_s;
  logic [3:0]    elapsed_r, elapsed_s;
  logic [3:0]    char_idx_r, char_idx_s;
  logic [3:0]    error_cnt_r, error_cnt_s;
  logic [1:0]    result_r, result_s;
  logic          timer_clear_r, timer_clear_s;
  logic          tick_s;

  // Next-state and counter update logic for the round sequencer.
  always_comb begin
    state_s       = state_r;
    presc_s       = presc_r;
    countdown_s   = countdown_r;
    elapsed_s     = elapsed_r;
    char_idx_s    = char_idx_r;
    error_cnt_s   = error_cnt_r;
    result_s      = result_r;
    timer_clear_s = 1'b0;
    tick_s        = (presc_r == PRESC_LAST);

    case (state_r)
      ST_IDLE, ST_DONE: begin
        presc_s = '0;
        if (bus.start) begin
          state_s       = ST_COUNTDOWN;
          countdown_s   = CD_LOAD;
          elapsed_s     = 4'd0;
          char_idx_s    = 4'd0;
          error_cnt_s   = 4'd0;
          result_s      = 2'd0;
          timer_clear_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end

      ST_COUNTDOWN: begin
        if (tick_s) begin
          presc_s     = '0;
          countdown_s = countdown_r - 4'd1;
          if (countdown_r == 4'd1) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_COUNTDOWN;
          end
        end else begin
          presc_s = presc_r + PW'(1);
        end
      end

      ST_RUN: begin
        if (tick_s) begin
          presc_s   = '0;
          elapsed_s = elapsed_r + 4'd1;
        end else begin
          presc_s   = presc_r + PW'(1);
          elapsed_s = elapsed_r;
        end
        if (bus.key_valid) begin
          if (bus.key_correct) begin
            char_idx_s = char_idx_r + 4'd1;
          end else begin
            error_cnt_s = error_cnt_r + 4'd1;
          end
        end else begin
          char_idx_s = char_idx_r;
        end
        // Exit checks use the updated counts so a same-cycle key beats timeout.
        if (char_idx_s == WL_VAL) begin
          state_s  = ST_DONE;
          result_s = 2'd1;
          presc_s  = '0;
        end else if (error_cnt_s == ME_VAL) begin
          state_s  = ST_DONE;
          result_s = 2'd3;
          presc_s  = '0;
        end else if (elapsed_s == TL_VAL) begin
          state_s  = ST_DONE;
          result_s = 2'd2;
          presc_s  = '0;
        end else if (bus.pause) begin
          state_s = ST_PAUSED;
        end else begin
          state_s = ST_RUN;
        end
      end

      ST_PAUSED: begin
        if (!bus.pause) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_PAUSED;
        end
      end

      default: begin
        state_s = ST_IDLE;
        presc_s = '0;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      presc_r       <= '0;
      countdown_r   <= 4'd0;
      elapsed_r     <= 4'd0;
      char_idx_r    <= 4'd0;
      error_cnt_r   <= 4'd0;
      result_r      <= 2'd0;
      timer_clear_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      presc_r       <= presc_s;
      countdown_r   <= countdown_s;
      elapsed_r     <= elapsed_s;
      char_idx_r    <= char_idx_s;
      error_cnt_r   <= error_cnt_s;
      result_r      <= result_s;
      timer_clear_r <= timer_clear_s;
    end
  end

  assign bus.state        = state_r;
  assign bus.timer_clear  = timer_clear_r;
  assign bus.timer_enable = (state_r == ST_RUN);
  assign bus.countdown    = countdown_r;
  assign bus.elapsed      = elapsed_r;
  assign bus.char_idx     = char_idx_r;
  assign bus.error_cnt    = error_cnt_r;
  assign bus.done         = (state_r == ST_DONE);
  assign bus.result       = result_r;

endmodule

// File: tb/tb_typing_round_ctrl.sv
// Self-checking bench for typing_round_ctrl: directed table, corner-case
// sequences and randomized traffic against a cycle-count based reference model.
module tb_typing_round_ctrl;
  localparam int TD = 4, CDN = 3, TL = 15, WL = 8, ME = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  typing_round_if bus ();

  typing_round_ctrl #(
    .TICK_DIV(TD), .COUNTDOWN(CDN), .TIME_LIMIT(TL), .WORD_LEN(WL), .MAX_ERRORS(ME)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase plus raw cycle counts; displayed values are derived by division.
  int m_state, m_cd_cyc, m_run_cyc, m_ci, m_ec, m_res;
  bit m_tclr;

  typedef struct {
    bit r, s, p, kv, kc;
    int st, tc, cd, el, ci, ec, res;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, s, p, kv, kc);
    if (r) begin
      m_state = 0; m_cd_cyc = 0; m_run_cyc = 0;
      m_ci = 0; m_ec = 0; m_res = 0; m_tclr = 1'b0;
    end else begin
      m_tclr = 1'b0;
      case (m_state)
        0, 4: begin
          if (s) begin
            m_state = 1; m_cd_cyc = 0; m_run_cyc = 0;
            m_ci = 0; m_ec = 0; m_res = 0; m_tclr = 1'b1;
          end
        end
        1: begin
          m_cd_cyc++;
          if (m_cd_cyc == CDN * TD) m_state = 2;
        end
        2: begin
          m_run_cyc++;
          if (kv) begin
            if (kc) m_ci++;
            else    m_ec++;
          end
          if (m_ci == WL)                  begin m_state = 4; m_res = 1; end
          else if (m_ec == ME)             begin m_state = 4; m_res = 3; end
          else if (m_run_cyc / TD == TL)   begin m_state = 4; m_res = 2; end
          else if (p)                      m_state = 3;
        end
        3: if (!p) m_state = 2;
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".state"},        bus.state,        m_state);
    check({tag, ".timer_clear"},  bus.timer_clear,  m_tclr);
    check({tag, ".timer_enable"}, bus.timer_enable, (m_state == 2));
    check({tag, ".countdown"},    bus.countdown,    (m_state == 1) ? CDN - m_cd_cyc / TD : 0);
    check({tag, ".elapsed"},      bus.elapsed,      m_run_cyc / TD);
    check({tag, ".char_idx"},     bus.char_idx,     m_ci);
    check({tag, ".error_cnt"},    bus.error_cnt,    m_ec);
    check({tag, ".done"},         bus.done,         (m_state == 4));
    check({tag, ".result"},       bus.result,       m_res);
  endtask

  task automatic step(input string tag, input bit r, s, p, kv, kc);
    reset = r; bus.start = s; bus.pause = p; bus.key_valid = kv; bus.key_correct = kc;
    @(posedge clk);
    model_step(r, s, p, kv, kc);
    @(negedge clk);
    compare_model(tag);
  endtask

  task automatic idle_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic void add(input bit r, s, p, kv, kc, input int st, tc, cd, el, ci, ec, res);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.kv = kv; v.kc = kc;
    v.st = st; v.tc = tc; v.cd = cd; v.el = el; v.ci = ci; v.ec = ec; v.res = res;
    tbl.push_back(v);
  endfunction

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.pause = 1'b0;
    bus.key_valid = 1'b0; bus.key_correct = 1'b0;

    // Directed table: reset, countdown pacing, first RUN keys, pause freeze, reset mid-RUN.
    add(1,0,0,0,0, 0,0,0,0,0,0,0);
    add(0,1,0,0,0, 1,1,3,0,0,0,0);
    add(0,1,0,1,1, 1,0,3,0,0,0,0);
    add(0,0,1,1,0, 1,0,3,0,0,0,0);
    add(0,0,0,0,0, 1,0,3,0,0,0,0);
    add(0,0,0,0,0, 1,0,2,0,0,0,0);
    add(0,0,0,0,0, 1,0,2,0,0,0,0);
    add(0,0,0,0,0, 1,0,2,0,0,0,0);
    add(0,0,0,0,0, 1,0,2,0,0,0,0);
    add(0,0,0,0,0, 1,0,1,0,0,0,0);
    add(0,0,0,0,0, 1,0,1,0,0,0,0);
    add(0,0,0,0,0, 1,0,1,0,0,0,0);
    add(0,0,0,0,0, 1,0,1,0,0,0,0);
    add(0,0,0,0,0, 2,0,0,0,0,0,0);
    add(0,0,0,1,1, 2,0,0,0,1,0,0);
    add(0,0,0,1,0, 2,0,0,0,1,1,0);
    add(0,0,1,0,0, 3,0,0,0,1,1,0);
    add(0,0,1,1,1, 3,0,0,0,1,1,0);
    add(0,0,0,0,0, 2,0,0,0,1,1,0);
    add(0,0,0,0,0, 2,0,0,1,1,1,0);
    add(1,0,0,1,1, 0,0,0,0,0,0,0);
    foreach (tbl[i]) begin
      step($sformatf("tbl%0d", i), tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].kv, tbl[i].kc);
      check($sformatf("tbl%0d.state", i),     bus.state,        tbl[i].st);
      check($sformatf("tbl%0d.tclr", i),      bus.timer_clear,  tbl[i].tc);
      check($sformatf("tbl%0d.countdown", i), bus.countdown,    tbl[i].cd);
      check($sformatf("tbl%0d.elapsed", i),   bus.elapsed,      tbl[i].el);
      check($sformatf("tbl%0d.char_idx", i),  bus.char_idx,     tbl[i].ci);
      check($sformatf("tbl%0d.error_cnt", i), bus.error_cnt,    tbl[i].ec);
      check($sformatf("tbl%0d.result", i),    bus.result,       tbl[i].res);
      check($sformatf("tbl%0d.ten", i),       bus.timer_enable, (tbl[i].st == 2));
    end

    // Eight correct keys, two cycles apart: completion, then counters frozen in DONE.
    step("wc_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps("wc_cd", 12);
    for (int k = 1; k <= WL; k++) begin
      step("wc_key", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("wc_char_idx", bus.char_idx, k);
      if (k < WL) step("wc_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("wc_result", bus.result, 2'd1);
    check("wc_done", bus.done, 1'b1);
    check("wc_elapsed", bus.elapsed, 4'd3);
    step("wc_hold_key", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_steps("wc_hold", 5);
    check("wc_elapsed_frozen", bus.elapsed, 4'd3);

    // Restart from DONE, then timeout after 60 RUN cycles.
    step("to_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("to_tclr", bus.timer_clear, 1'b1);
    check("to_cleared_ci", bus.char_idx, 4'd0);
    check("to_cleared_res", bus.result, 2'd0);
    idle_steps("to_cd", 12);
    idle_steps("to_run", 59);
    check("to_pre_state", bus.state, 3'd2);
    check("to_pre_elapsed", bus.elapsed, 4'd14);
    idle_steps("to_last", 1);
    check("to_state", bus.state, 3'd4);
    check("to_result", bus.result, 2'd2);
    check("to_ten_drop", bus.timer_enable, 1'b0);

    // Three wrong keys.
    step("er_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps("er_cd", 12);
    for (int k = 0; k < ME; k++) step("er_key", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("er_cnt", bus.error_cnt, 4'd3);
    check("er_result", bus.result, 2'd3);

    // Eighth correct key lands on the final tick: completion beats timeout.
    step("race_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps("race_cd", 12);
    for (int c = 1; c <= 59; c++)
      step("race_run", 1'b0, 1'b0, 1'b0, (c <= 13) && (c % 2 == 1), 1'b1);
    step("race_last", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("race_result", bus.result, 2'd1);
    check("race_elapsed", bus.elapsed, 4'd15);

    // Pause held 10 cycles with keys pressed, then run out the clock.
    step("pz_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps("pz_cd", 12);
    idle_steps("pz_run", 6);
    for (int i = 0; i < 10; i++) step("pz_hold", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("pz_state", bus.state, 3'd3);
    check("pz_char_idx", bus.char_idx, 4'd1);
    check("pz_elapsed", bus.elapsed, 4'd1);
    for (int i = 0; i < 80 && bus.done !== 1'b1; i++)
      step("pz_rest", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pz_result", bus.result, 2'd2);
    step("pz_done_key", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("pz_done_ci", bus.char_idx, 4'd1);

    // Randomized traffic against the model.
    begin
      bit p = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 11) == 0) p = ~p;
        step("rnd", ($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), p,
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 6) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/typing_round_ctrl.md
Name: typing_round_ctrl

Overview:
Round sequencer for the typing tutor. It arms and clears the round timer, runs a pre-round countdown, and scores keystrokes against the current word. It ends the round on word completion, error limit or time limit, and holds the result for the display/score logic. It sits between the keyboard decode/compare stage and the timer/display blocks.

Parameters:
TICK_DIV, 4, clocks per time unit (prescaler period), >=2
COUNTDOWN, 3, time units of pre-round countdown, 1..15
TIME_LIMIT, 15, round length in time units, 1..15
WORD_LEN, 8, characters per word, 1..15
MAX_ERRORS, 3, error count that aborts the round, 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; clock clk
start  in  1  level; sampled in IDLE and DONE
pause  in  1  level; freezes the round while in RUN
key_valid  in  1  one-cycle strobe, a keystroke was compared
key_correct  in  1  compare result, qualified by key_valid
state  out  3  0 IDLE, 1 COUNTDOWN, 2 RUN, 3 PAUSED, 4 DONE
timer_clear  out  1  one-cycle pulse on entry to COUNTDOWN
timer_enable  out  1  high iff state==RUN
countdown  out  4  remaining countdown units
elapsed  out  4  time units elapsed in RUN
char_idx  out  4  correct characters typed (next char position)
error_cnt  out  4  wrong keystrokes this round
done  out  1  high iff state==DONE
result  out  2  0 none, 1 complete, 2 timeout, 3 too many errors

Behaviour:
- Reset (synchronous, any state, mid-round included): state=IDLE, all counters 0, prescaler 0, result=0, timer_clear=0. Reset wins over every other input.
- Prescaler: counts 0..TICK_DIV-1 only in COUNTDOWN and RUN; holds in PAUSED; cleared in IDLE/DONE and on COUNTDOWN->RUN. tick = prescaler==TICK_DIV-1 (internal).
- IDLE: start=1 -> COUNTDOWN next edge; load countdown=COUNTDOWN; clear elapsed, char_idx, error_cnt, result; pulse timer_clear for exactly that first COUNTDOWN cycle.
- COUNTDOWN: countdown decrements on tick. On the tick where countdown==1, go to RUN with countdown=0. COUNTDOWN lasts COUNTDOWN*TICK_DIV cycles. Keys and pause are ignored.
- RUN: on tick, elapsed += 1. If key_valid: key_correct=1 -> char_idx += 1, else error_cnt += 1. pause=1 -> PAUSED next edge; that cycle's key and tick are still processed.
- PAUSED: all counters frozen, keys ignored, timer_enable=0. pause=0 -> RUN next edge.
- Exit from RUN (same edge as the counter update), priority highest first:
  1. char_idx reaches WORD_LEN -> DONE, result=1
  2. error_cnt reaches MAX_ERRORS -> DONE, result=3
  3. elapsed reaches TIME_LIMIT -> DONE, result=2
- A keystroke and the final tick in the same cycle: the key is counted, and completion or errors beat timeout.
- Exit priority is evaluated before pause: an exit on the same cycle as pause=1 goes to DONE.
- DONE: all counters hold (final values visible); done=1. start=1 -> COUNTDOWN with the same initialisation as from IDLE (timer_clear pulse).
- Counters never wrap. Exit conditions guarantee each counter stops at its limit, and all are 4-bit.
- Outputs are registered except timer_enable and done, which decode state.

Test Plan:
- Defaults; reset, start for 1 cycle -> timer_clear high 1 cycle; COUNTDOWN 3->2->1 at 4-cycle spacing; RUN entered 12 cycles after COUNTDOWN entry, timer_enable=1.
- 8 key_valid with key_correct=1, 2 cycles apart, in RUN -> char_idx 1..8, DONE on 8th key edge, result=1, done=1, elapsed frozen.
- No keys in RUN -> elapsed 1..15 every 4 cycles; DONE after 60 RUN cycles, result=2, timer_enable drops with it.
- 3 wrong keys (key_correct=0) -> error_cnt=3, DONE result=3. 8th correct key on the same cycle as the final tick -> result=1, not 2.
- pause held 10 cycles mid-RUN -> state=3, elapsed/prescaler/char_idx frozen, keys ignored; release -> RUN resumes, total RUN ticks unchanged. Reset asserted mid-RUN -> IDLE, all outputs 0 next edge.
- In DONE, start=1 -> COUNTDOWN, counters cleared, result=0, timer_clear pulse. key_valid in IDLE/COUNTDOWN/DONE -> no counter change.
